// File: rtl/prog3_data_loader.sv
// prog3_data_loader
// Feeds the nearest-pair core (program 3) with its input samples. Signed
// samples arrive over a valid/ready handshake and pass through a small skid
// FIFO. They are then written to data memory at BASE_ADDR, BASE_ADDR+1, ...
// Once COUNT samples are committed, load_done rises and core_go pulses for
// one cycle. A mod-256 checksum and the running signed min/max of the written
// samples are kept for cross-checking.
//
// Ports:
//   clk        system clock, rising edge
//   init       asynchronous active-high reset
//   load_start one-cycle pulse that begins a load (honoured in IDLE/DONE)
//   in_valid   upstream sample valid
//   in_data    signed sample
//   in_ready   block accepts in_data this cycle
//   mem_gnt    memory port granted to the loader this cycle
//   mem_we     registered write enable
//   mem_addr   registered write address
//   mem_wdata  registered write data
//   load_done  level, all COUNT samples committed
//   core_go    one-cycle start pulse to the core
//   checksum   sum of written samples mod 256
//   min_val    signed minimum of written samples
//   max_val    signed maximum of written samples
module prog3_data_loader #(
    parameter int BASE_ADDR  = 128,
    parameter int COUNT      = 20,
    parameter int DW         = 8,
    parameter int AW         = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          init,
    input  logic          load_start,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    input  logic          mem_gnt,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          load_done,
    output logic          core_go,
    output logic [7:0]    checksum,
    output logic [DW-1:0] min_val,
    output logic [DW-1:0] max_val
);

    localparam int            PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [7:0]    COUNT_C = 8'(COUNT);
    localparam logic [7:0]    LAST_C  = 8'(COUNT - 1);
    localparam logic [AW-1:0] BASE_C  = AW'(BASE_ADDR);
    localparam logic [PW:0]   DEPTH_C = (PW + 1)'(FIFO_DEPTH);
    localparam logic [PW:0]   EMPTY_C = {(PW + 1){1'b0}};
    localparam logic [PW-1:0] PTR1_C  = PW'(1);
    // Most positive / most negative signed values: start points for min/max
    localparam logic [DW-1:0] SMAX_C  = {1'b0, {(DW - 1){1'b1}}};
    localparam logic [DW-1:0] SMIN_C  = {1'b1, {(DW - 1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_r;
    logic [DW-1:0] fifo_mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW:0]   fifo_cnt_r;
    logic [7:0]    acc_cnt_r;
    logic [7:0]    wr_cnt_r;

    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic          push_s;
    logic          pop_s;
    logic [DW-1:0] head_s;

    // Handshake and FIFO control. in_ready depends only on registered state,
    // so a pop in the same cycle never frees a slot for a push.
    always_comb begin
        fifo_full_s  = (fifo_cnt_r == DEPTH_C);
        fifo_empty_s = (fifo_cnt_r == EMPTY_C);
        head_s       = fifo_mem_r[rd_ptr_r];
        if (state_r == ST_LOAD) begin
            in_ready = !fifo_full_s && (acc_cnt_r < COUNT_C);
            pop_s    = !fifo_empty_s && mem_gnt;
        end else begin
            in_ready = 1'b0;
            pop_s    = 1'b0;
        end
        push_s = in_valid && in_ready;
    end

    // FIFO storage; contents need no reset, occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= in_data;
        end
    end

    // Control FSM, counters, memory write port and statistics.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state_r    <= ST_IDLE;
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            fifo_cnt_r <= EMPTY_C;
            acc_cnt_r  <= 8'd0;
            wr_cnt_r   <= 8'd0;
            mem_we     <= 1'b0;
            mem_addr   <= BASE_C;
            mem_wdata  <= {DW{1'b0}};
            load_done  <= 1'b0;
            core_go    <= 1'b0;
            checksum   <= 8'd0;
            min_val    <= SMAX_C;
            max_val    <= SMIN_C;
        end else begin
            core_go <= 1'b0;
            mem_we  <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (load_start) begin
                        state_r    <= ST_LOAD;
                        wr_ptr_r   <= {PW{1'b0}};
                        rd_ptr_r   <= {PW{1'b0}};
                        fifo_cnt_r <= EMPTY_C;
                        acc_cnt_r  <= 8'd0;
                        wr_cnt_r   <= 8'd0;
                        load_done  <= 1'b0;
                        checksum   <= 8'd0;
                        min_val    <= SMAX_C;
                        max_val    <= SMIN_C;
                    end
                end
                ST_LOAD: begin
                    if (push_s) begin
                        wr_ptr_r  <= wr_ptr_r + PTR1_C;
                        acc_cnt_r <= acc_cnt_r + 8'd1;
                    end
                    if (pop_s) begin
                        rd_ptr_r  <= rd_ptr_r + PTR1_C;
                        mem_we    <= 1'b1;
                        mem_addr  <= BASE_C + AW'(wr_cnt_r);
                        mem_wdata <= head_s;
                        wr_cnt_r  <= wr_cnt_r + 8'd1;
                        checksum  <= checksum + 8'(head_s);
                        if ($signed(head_s) < $signed(min_val)) begin
                            min_val <= head_s;
                        end
                        if ($signed(head_s) > $signed(max_val)) begin
                            max_val <= head_s;
                        end
                        // The COUNT-th write finishes the load on this edge
                        if (wr_cnt_r == LAST_C) begin
                            state_r   <= ST_DONE;
                            core_go   <= 1'b1;
                            load_done <= 1'b1;
                        end
                    end
                    case ({push_s, pop_s})
                        2'b10:   fifo_cnt_r <= fifo_cnt_r + (PW + 1)'(1);
                        2'b01:   fifo_cnt_r <= fifo_cnt_r - (PW + 1)'(1);
                        default: fifo_cnt_r <= fifo_cnt_r;
                    endcase
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog3_data_loader.sv
module tb_prog3_data_loader;

    logic       clk = 1'b0;
    logic       init;
    logic       load_start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mem_gnt;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       load_done;
    logic       core_go;
    logic [7:0] checksum;
    logic [7:0] min_val;
    logic [7:0] max_val;

    prog3_data_loader dut (
        .clk        (clk),
        .init       (init),
        .load_start (load_start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_gnt    (mem_gnt),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .load_done  (load_done),
        .core_go    (core_go),
        .checksum   (checksum),
        .min_val    (min_val),
        .max_val    (max_val)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  src_q[$];
    logic [15:0] exp_q[$];
    logic [7:0]  sent[$];
    logic [7:0]  mem_m [256];
    bit          wrote [256];
    int          cyc = 0;
    int          acc_seen, wr_seen, go_cnt, first_acc_cyc, last_we_cyc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_src();
        in_valid = (src_q.size() > 0);
        in_data  = in_valid ? src_q[0] : 8'h00;
    endtask

    // One clock: observe at negedge, scoreboard writes/accepts, redrive after posedge
    task automatic run_cycle();
        logic        acc;
        logic [15:0] e;
        @(negedge clk);
        if (mem_we === 1'b1) begin
            wr_seen++;
            last_we_cyc = cyc;
            wrote[mem_addr] = 1'b1;
            mem_m[mem_addr] = mem_wdata;
            if (exp_q.size() == 0) begin
                check_val("write_without_accept", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                check_val("wr_addr", {24'd0, mem_addr}, {24'd0, e[15:8]});
                check_val("wr_data", {24'd0, mem_wdata}, {24'd0, e[7:0]});
            end
        end
        if (core_go === 1'b1) go_cnt++;
        acc = (in_valid === 1'b1) && (in_ready === 1'b1);
        if (acc) begin
            if (acc_seen == 0) first_acc_cyc = cyc;
            exp_q.push_back({8'(128 + acc_seen), in_data});
            sent.push_back(in_data);
            acc_seen++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (acc) src_q.delete(0);
        drive_src();
    endtask

    task automatic new_load();
        exp_q.delete();
        sent.delete();
        acc_seen = 0;
        wr_seen  = 0;
        go_cnt   = 0;
        for (int i = 0; i < 256; i++) wrote[i] = 1'b0;
        drive_src();
        load_start = 1'b1;
        run_cycle();
        load_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (load_done !== 1'b1 && n < budget) begin
            run_cycle();
            n++;
        end
        check_val("done_timeout", {31'd0, load_done}, 32'd1);
        run_cycle();
        run_cycle();
    endtask

    task automatic check_results(input int n);
        int s = 0, mn = 127, mx = -128, v;
        for (int i = 0; i < sent.size(); i++) begin
            v = $signed(sent[i]);
            s += v;
            if (v < mn) mn = v;
            if (v > mx) mx = v;
        end
        check_val("accepts", acc_seen, n);
        check_val("writes", wr_seen, n);
        check_val("core_go_pulses", go_cnt, 1);
        check_val("sb_empty", exp_q.size(), 0);
        check_val("load_done", {31'd0, load_done}, 32'd1);
        check_val("checksum", {24'd0, checksum}, {24'd0, 8'(s)});
        check_val("min_val", {24'd0, min_val}, {24'd0, 8'(mn)});
        check_val("max_val", {24'd0, max_val}, {24'd0, 8'(mx)});
        for (int i = 0; i < n; i++) begin
            check_val("mem_content", {24'd0, mem_m[128 + i]}, {24'd0, sent[i]});
        end
        check_val("no_write_past_end", {31'd0, wrote[128 + n]}, 32'd0);
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check_val({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        check_val({tag, "_mem_addr"}, {24'd0, mem_addr}, 32'd128);
        check_val({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
        check_val({tag, "_load_done"}, {31'd0, load_done}, 32'd0);
        check_val({tag, "_core_go"}, {31'd0, core_go}, 32'd0);
        check_val({tag, "_checksum"}, {24'd0, checksum}, 32'd0);
        check_val({tag, "_min"}, {24'd0, min_val}, 32'h7F);
        check_val({tag, "_max"}, {24'd0, max_val}, 32'h80);
    endtask

    initial begin
        init       = 1'b1;
        load_start = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        mem_gnt    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst");
        init = 1'b0;

        // Ramp -10..9 at full rate
        for (int i = 0; i < 20; i++) src_q.push_back(8'(i - 10));
        new_load();
        wait_done(100);
        check_results(20);
        check_val("ramp_checksum", {24'd0, checksum}, 32'hF6);
        check_val("ramp_min", {24'd0, min_val}, 32'hF6);
        check_val("ramp_max", {24'd0, max_val}, 32'h09);
        check_val("ramp_latency", last_we_cyc - first_acc_cyc, 21);

        // Grant withheld for 10 cycles: FIFO fills after 4 accepts
        mem_gnt = 1'b0;
        for (int i = 0; i < 20; i++) src_q.push_back(8'(i * 7 - 60));
        new_load();
        repeat (10) run_cycle();
        check_val("stall_accepts", acc_seen, 4);
        check_val("stall_in_ready", {31'd0, in_ready}, 32'd0);
        check_val("stall_no_writes", wr_seen, 0);
        mem_gnt = 1'b1;
        wait_done(100);
        check_results(20);

        // 25 samples offered, only 20 taken
        for (int i = 0; i < 25; i++) src_q.push_back(8'(i * 5 + 3));
        new_load();
        wait_done(100);
        check_results(20);
        check_val("over_in_ready", {31'd0, in_ready}, 32'd0);
        check_val("over_leftover", src_q.size(), 5);
        src_q.delete();
        drive_src();

        // Reset after 7 writes, then a fresh load
        for (int i = 0; i < 20; i++) src_q.push_back(8'(100 - i * 9));
        new_load();
        for (int n = 0; n < 100 && wr_seen < 7; n++) run_cycle();
        check_val("mid_writes", wr_seen, 7);
        init = 1'b1;
        #1;
        check_reset("mid_rst");
        src_q.delete();
        drive_src();
        @(posedge clk);
        #1;
        init = 1'b0;
        for (int i = 0; i < 20; i++) src_q.push_back(8'(i * 3 - 30));
        new_load();
        wait_done(100);
        check_results(20);

        // All 127
        for (int i = 0; i < 20; i++) src_q.push_back(8'h7F);
        new_load();
        wait_done(100);
        check_results(20);
        check_val("sat_checksum", {24'd0, checksum}, 32'hEC);
        check_val("sat_min", {24'd0, min_val}, 32'h7F);
        check_val("sat_max", {24'd0, max_val}, 32'h7F);

        // load_start during LOAD ignored, in DONE restarts
        for (int i = 0; i < 20; i++) src_q.push_back(8'(i * 11));
        new_load();
        for (int n = 0; n < 100 && acc_seen < 5; n++) run_cycle();
        load_start = 1'b1;
        run_cycle();
        load_start = 1'b0;
        wait_done(100);
        check_results(20);
        for (int i = 0; i < 20; i++) src_q.push_back(8'(50 - i));
        new_load();
        check_val("restart_done_clear", {31'd0, load_done}, 32'd0);
        wait_done(100);
        check_results(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
